jtag_ir_unit: RTL and testbench

Instruction-register stage for the JTAG TAP. It sits between the TAP controller's IR-path strobes and the TAP data-register mux and TDO retiming.
- Captures the status pattern, shifts the instruction in and out, and validates opcodes at Update-IR.
- Gates private opcodes behind a two-step unlock state machine.
- Decodes the active instruction into data-register selects and boundary-scan mode bits.

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_ir_lock_fsm.sv | 36 +++
 rtl/jtag_ir_unit.sv | 139 +++++++++++++
 tb/tb_jtag_ir_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG instruction-register slice.
package jtag_pkg;

    localparam int IR_WIDTH_DEF = 4;

    localparam logic [3:0] OPC_BYPASS         = 4'b1111;
    localparam logic [3:0] OPC_SAMPLE_PRELOAD = 4'b0101;
    localparam logic [3:0] OPC_EXTEST         = 4'b0110;
    localparam logic [3:0] OPC_NOP            = 4'b0001;
    localparam logic [3:0] OPC_IDCODE         = 4'b1001;
    localparam logic [3:0] OPC_INTEST         = 4'b0100;
    localparam logic [3:0] OPC_UNLOCK         = 4'b1010;
    localparam logic [3:0] OPC_PRIV           = 4'b0011;

    localparam logic [1:0] CAPTURE_LOW = 2'b01;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic bypass;
        logic idcode;
        logic bsr;
        logic priv;
        logic drive_out;
        logic drive_core;
    } ir_dec_t;

endpackage

// File: rtl/jtag_ir_lock_fsm.sv
// Two-step unlock gate for the private opcode; UNLOCKED is sticky until Resetn.
module jtag_ir_lock_fsm
    import jtag_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic        ClockIR,
    input  logic        Resetn,
    input  logic        update_valid,
    input  logic        op_is_unlock,
    output lock_state_e state
);

    lock_state_e r_state;

    // Advance on every update strobe; op_is_unlock is already qualified by a full-length shift.
    always_ff @(posedge ClockIR or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= LOCKED;
        end else if (!ENABLE) begin
            r_state <= LOCKED;
        end else if (update_valid) begin
            case (r_state)
                LOCKED:   r_state <= op_is_unlock ? ARMED : LOCKED;
                ARMED:    r_state <= op_is_unlock ? UNLOCKED : LOCKED;
                UNLOCKED: r_state <= UNLOCKED;
                default:  r_state <= LOCKED;
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/jtag_ir_unit.sv
// JTAG instruction register: capture/shift/update, opcode validation with
// private-opcode lock, and decode into data-register selects.
module jtag_ir_unit
    import jtag_pkg::*;
#(
    parameter int         IR_WIDTH      = IR_WIDTH_DEF,
    parameter bit         PRIV_ENABLE   = 1'b1,
    parameter logic [3:0] UNLOCK_OPCODE = OPC_UNLOCK,
    parameter logic [3:0] PRIV_OPCODE   = OPC_PRIV
) (
    input  logic                ClockIR,
    input  logic                Resetn,
    input  logic                CaptureIR,
    input  logic                ShiftIR,
    input  logic                UpdateIR,
    input  logic                TDI,
    input  logic [1:0]          status_in,
    output logic                ir_tdo,
    output logic [IR_WIDTH-1:0] instr,
    output logic                sel_bypass,
    output logic                sel_idcode,
    output logic                sel_bsr,
    output logic                sel_priv,
    output logic                bs_drive_out,
    output logic                bs_drive_core,
    output logic                locked,
    output logic                short_shift
);

    localparam int CNT_W = $clog2(IR_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IR_WIDTH);

    localparam logic [IR_WIDTH-1:0] W_BYPASS  = '1;
    localparam logic [IR_WIDTH-1:0] W_SAMPLE  = IR_WIDTH'(OPC_SAMPLE_PRELOAD);
    localparam logic [IR_WIDTH-1:0] W_EXTEST  = IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] W_NOP     = IR_WIDTH'(OPC_NOP);
    localparam logic [IR_WIDTH-1:0] W_IDCODE  = IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] W_INTEST  = IR_WIDTH'(OPC_INTEST);
    localparam logic [IR_WIDTH-1:0] W_UNLOCK  = IR_WIDTH'(UNLOCK_OPCODE);
    localparam logic [IR_WIDTH-1:0] W_PRIV    = IR_WIDTH'(PRIV_OPCODE);

    function automatic ir_dec_t decode(input logic [IR_WIDTH-1:0] op);
        ir_dec_t d;
        d.bypass     = (op == W_BYPASS) || (op == W_NOP);
        d.idcode     = (op == W_IDCODE);
        d.bsr        = (op == W_SAMPLE) || (op == W_EXTEST) || (op == W_INTEST);
        d.priv       = (op == W_PRIV);
        d.drive_out  = (op == W_EXTEST) || (op == W_INTEST);
        d.drive_core = (op == W_INTEST);
        return d;
    endfunction

    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_instr;
    logic [CNT_W-1:0]    r_shift_cnt;
    logic                r_short_shift;
    ir_dec_t             r_dec;

    logic                w_update;
    logic                w_full;
    logic                w_public;
    logic [IR_WIDTH-1:0] w_instr_nxt;
    lock_state_e         w_lock_state;

    // Strobe priority Capture > Shift > Update, and next-instruction selection.
    always_comb begin
        w_update    = UpdateIR && !CaptureIR && !ShiftIR;
        w_full      = (r_shift_cnt == CNT_MAX);
        w_public    = (r_ir_shift == W_BYPASS) || (r_ir_shift == W_SAMPLE) ||
                      (r_ir_shift == W_EXTEST) || (r_ir_shift == W_NOP)    ||
                      (r_ir_shift == W_IDCODE) || (r_ir_shift == W_INTEST);
        w_instr_nxt = r_instr;
        if (w_update) begin
            if (!w_full) begin
                w_instr_nxt = W_BYPASS;
            end else if (w_public) begin
                w_instr_nxt = r_ir_shift;
            end else if ((r_ir_shift == W_PRIV) && (w_lock_state == UNLOCKED)) begin
                w_instr_nxt = r_ir_shift;
            end else begin
                w_instr_nxt = W_BYPASS;
            end
        end else begin
            w_instr_nxt = r_instr;
        end
    end

    // Shift register, shift counter and sticky short-shift flag.
    always_ff @(posedge ClockIR or negedge Resetn) begin
        if (!Resetn) begin
            r_ir_shift    <= W_NOP;
            r_shift_cnt   <= '0;
            r_short_shift <= 1'b0;
        end else if (CaptureIR) begin
            r_ir_shift  <= IR_WIDTH'({status_in, CAPTURE_LOW});
            r_shift_cnt <= '0;
        end else if (ShiftIR) begin
            r_ir_shift  <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
            r_shift_cnt <= w_full ? r_shift_cnt : r_shift_cnt + CNT_W'(1);
        end else if (w_update && !w_full) begin
            r_short_shift <= 1'b1;
        end else begin
            r_ir_shift <= r_ir_shift;
        end
    end

    // Decode is computed from the next instruction so selects move on the update edge.
    always_ff @(posedge ClockIR or negedge Resetn) begin
        if (!Resetn) begin
            r_instr <= W_IDCODE;
            r_dec   <= decode(W_IDCODE);
        end else begin
            r_instr <= w_instr_nxt;
            r_dec   <= decode(w_instr_nxt);
        end
    end

    jtag_ir_lock_fsm #(
        .ENABLE (PRIV_ENABLE)
    ) u_lock (
        .ClockIR      (ClockIR),
        .Resetn       (Resetn),
        .update_valid (w_update),
        .op_is_unlock (w_full && (r_ir_shift == W_UNLOCK)),
        .state        (w_lock_state)
    );

    assign ir_tdo        = r_ir_shift[0];
    assign instr         = r_instr;
    assign sel_bypass    = r_dec.bypass;
    assign sel_idcode    = r_dec.idcode;
    assign sel_bsr       = r_dec.bsr;
    assign sel_priv      = r_dec.priv;
    assign bs_drive_out  = r_dec.drive_out;
    assign bs_drive_core = r_dec.drive_core;
    assign locked        = (w_lock_state != UNLOCKED);
    assign short_shift   = r_short_shift;

endmodule

// File: tb/tb_jtag_ir_unit.sv
// Directed bench for jtag_ir_unit: a table of full-length IR loads plus
// hand-written capture/shift/reset sequences.
module tb_jtag_ir_unit;

    logic       ClockIR = 1'b0;
    logic       Resetn = 1'b0;
    logic       CaptureIR = 1'b0;
    logic       ShiftIR = 1'b0;
    logic       UpdateIR = 1'b0;
    logic       TDI = 1'b0;
    logic [1:0] status_in = 2'b00;
    logic       ir_tdo;
    logic [3:0] instr;
    logic       sel_bypass, sel_idcode, sel_bsr, sel_priv;
    logic       bs_drive_out, bs_drive_core, locked, short_shift;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ClockIR = ~ClockIR;

    jtag_ir_unit dut (
        .ClockIR       (ClockIR),
        .Resetn        (Resetn),
        .CaptureIR     (CaptureIR),
        .ShiftIR       (ShiftIR),
        .UpdateIR      (UpdateIR),
        .TDI           (TDI),
        .status_in     (status_in),
        .ir_tdo        (ir_tdo),
        .instr         (instr),
        .sel_bypass    (sel_bypass),
        .sel_idcode    (sel_idcode),
        .sel_bsr       (sel_bsr),
        .sel_priv      (sel_priv),
        .bs_drive_out  (bs_drive_out),
        .bs_drive_core (bs_drive_core),
        .locked        (locked),
        .short_shift   (short_shift)
    );

    typedef struct {
        logic [3:0] op;
        logic [3:0] exp_instr;
        logic [3:0] exp_sel;     // {bypass, idcode, bsr, priv}
        logic [1:0] exp_drive;   // {drive_out, drive_core}
        logic       exp_locked;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given strobes; outputs are stable #1 after the edge.
    task automatic cyc(input logic cap, input logic sh, input logic up, input logic tdi);
        @(negedge ClockIR);
        CaptureIR = cap;
        ShiftIR   = sh;
        UpdateIR  = up;
        TDI       = tdi;
        @(posedge ClockIR);
        #1;
        CaptureIR = 1'b0;
        ShiftIR   = 1'b0;
        UpdateIR  = 1'b0;
        TDI       = 1'b0;
    endtask

    task automatic load_ir(input logic [3:0] op, input int nshift);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < nshift; k++) cyc(1'b0, 1'b1, 1'b0, op[k]);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_instr"}, 32'(instr), 32'h9);
        chk({tag, "_sel"}, 32'({sel_bypass, sel_idcode, sel_bsr, sel_priv}), 32'h4);
        chk({tag, "_tdo"}, 32'(ir_tdo), 32'h1);
        chk({tag, "_locked"}, 32'(locked), 32'h1);
        chk({tag, "_short"}, 32'(short_shift), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{4'b0110, 4'b0110, 4'b0010, 2'b10, 1'b1};
        vecs[1]  = '{4'b0101, 4'b0101, 4'b0010, 2'b00, 1'b1};
        vecs[2]  = '{4'b0001, 4'b0001, 4'b1000, 2'b00, 1'b1};
        vecs[3]  = '{4'b1001, 4'b1001, 4'b0100, 2'b00, 1'b1};
        vecs[4]  = '{4'b0100, 4'b0100, 4'b0010, 2'b11, 1'b1};
        vecs[5]  = '{4'b1111, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[6]  = '{4'b0000, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[7]  = '{4'b0011, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[8]  = '{4'b0111, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[9]  = '{4'b1010, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[10] = '{4'b0110, 4'b0110, 4'b0010, 2'b10, 1'b1};
        vecs[11] = '{4'b0011, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[12] = '{4'b1010, 4'b1111, 4'b1000, 2'b00, 1'b1};
        vecs[13] = '{4'b1010, 4'b1111, 4'b1000, 2'b00, 1'b0};
        vecs[14] = '{4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b0};

        // Reset release with no strobes
        repeat (2) @(posedge ClockIR);
        @(negedge ClockIR);
        Resetn = 1'b1;
        repeat (2) @(posedge ClockIR);
        #1;
        chk_reset_state("reset");

        // Capture status 10 then shift 0,1,1,0 -> EXTEST
        status_in = 2'b10;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tdo_cap", 32'(ir_tdo), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("tdo_sh1", 32'(ir_tdo), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("tdo_sh2", 32'(ir_tdo), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("tdo_sh3", 32'(ir_tdo), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("instr_pre_upd", 32'(instr), 32'h9);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("extest_instr", 32'(instr), 32'h6);
        chk("extest_sel", 32'({sel_bypass, sel_idcode, sel_bsr, sel_priv}), 32'h2);
        chk("extest_drive", 32'({bs_drive_out, bs_drive_core}), 32'h2);
        status_in = 2'b00;

        // Table of full-length loads, including the lock sequences
        for (int i = 0; i < 15; i++) begin
            load_ir(vecs[i].op, 4);
            chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d_sel", i), 32'({sel_bypass, sel_idcode, sel_bsr, sel_priv}),
                32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_drive", i), 32'({bs_drive_out, bs_drive_core}),
                32'(vecs[i].exp_drive));
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
            chk($sformatf("vec%0d_short", i), 32'(short_shift), 32'h0);
        end

        // Short shift: two shifts then update
        load_ir(4'b0110, 2);
        chk("short_instr", 32'(instr), 32'hF);
        chk("short_sel", 32'({sel_bypass, sel_idcode, sel_bsr, sel_priv}), 32'h8);
        chk("short_flag", 32'(short_shift), 32'h1);
        chk("short_keeps_unlock", 32'(locked), 32'h0);
        load_ir(4'b1001, 4);
        chk("short_sticky_instr", 32'(instr), 32'h9);
        chk("short_sticky", 32'(short_shift), 32'h1);

        // Update with zero shifts
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("zero_shift_instr", 32'(instr), 32'hF);

        // Capture and Shift together: capture wins
        status_in = 2'b11;
        load_ir(4'b0110, 4);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("capshift_tdo", 32'(ir_tdo), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("capshift_tdo2", 32'(ir_tdo), 32'h0);
        chk("capshift_instr", 32'(instr), 32'h6);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("cap_over_upd", 32'(instr), 32'h6);
        status_in = 2'b00;

        // Reset asserted after two of four shifts of INTEST
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        Resetn = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge ClockIR);
        Resetn = 1'b1;
        load_ir(4'b0100, 4);
        chk("intest_instr", 32'(instr), 32'h4);
        chk("intest_drive", 32'({bs_drive_out, bs_drive_core}), 32'h3);
        chk("intest_sel", 32'({sel_bypass, sel_idcode, sel_bsr, sel_priv}), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
